vae_layer_sequencer: RTL

//  Handshaked sequencer for the arrhythmia VAE datapath. Replaces fixed-schedule control.

---
 rtl/vae_layer_sequencer_pkg.sv | 23 ++
 rtl/vae_layer_sequencer_timer.sv | 28 ++
 rtl/vae_layer_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vae_layer_sequencer_pkg.sv
// Shared definitions for the VAE layer sequencer: state encodings, stage indices, sizes.
package vae_layer_sequencer_pkg;

    localparam int unsigned NUM_STAGES = 5;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned FRAME_W    = 16;

    localparam logic [IDX_W-1:0] ENC1     = 3'd0;
    localparam logic [IDX_W-1:0] ENC2     = 3'd1;
    localparam logic [IDX_W-1:0] LAMBDA   = 3'd2;
    localparam logic [IDX_W-1:0] ENC3     = 3'd3;
    localparam logic [IDX_W-1:0] ENC4     = 3'd4;
    localparam logic [IDX_W-1:0] IDX_NONE = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        CAPT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/vae_layer_sequencer_timer.sv
// Per-stage cycle counter: clear, saturating increment, latency hit and watchdog compare.
module vae_layer_sequencer_timer #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit     = (cnt == limit);
    assign timeout = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/vae_layer_sequencer.sv
// Handshaked five-stage sequencer for the VAE datapath; SEQ_TIMEOUT_EN enables the
// watchdog ERR state and sticky err output.
module vae_layer_sequencer
    import vae_layer_sequencer_pkg::*;
#(
    parameter logic [NUM_STAGES-1:0] DONE_MASK = 5'b11001,
    parameter int unsigned           LAT_0     = 48,
    parameter int unsigned           LAT_1     = 48,
    parameter int unsigned           LAT_2     = 8,
    parameter int unsigned           LAT_3     = 24,
    parameter int unsigned           LAT_4     = 24,
    parameter int unsigned           CNT_W     = 10,
    parameter int unsigned           TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_clr,
    output logic [NUM_STAGES-1:0] capture_en,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [FRAME_W-1:0]    frame_cnt
);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        k, k_nxt;
    logic [NUM_STAGES-1:0]   clr_nxt, cap_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    busy_nxt, done_nxt;
    logic [FRAME_W-1:0]      frame_nxt;
    logic [CNT_W-1:0]        lat_limit;
    logic                    hit, timeout, stage_complete;

    // Terminal count for the active stage: it runs exactly LAT_k cycles.
    always_comb begin
        case (k)
            ENC1:    lat_limit = CNT_W'(LAT_0 - 1);
            ENC2:    lat_limit = CNT_W'(LAT_1 - 1);
            LAMBDA:  lat_limit = CNT_W'(LAT_2 - 1);
            ENC3:    lat_limit = CNT_W'(LAT_3 - 1);
            default: lat_limit = CNT_W'(LAT_4 - 1);
        endcase
    end

    vae_layer_sequencer_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .inc     (state == RUN),
        .limit   (lat_limit),
        .hit     (hit),
        .timeout (timeout)
    );

    assign stage_complete = DONE_MASK[k] ? stage_done[k] : hit;

`ifdef SEQ_TIMEOUT_EN
    logic err_q, err_nxt;
`else
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif

    // Next state; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        frame_nxt = frame_cnt;
`ifdef SEQ_TIMEOUT_EN
        err_nxt   = err_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    k_nxt     = ENC1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (stage_complete) begin
                    state_nxt = CAPT;
`ifdef SEQ_TIMEOUT_EN
                end else if (DONE_MASK[k] && timeout) begin
                    state_nxt = ERR;
                    err_nxt   = 1'b1;
`endif
                end
            end
            CAPT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (k == ENC4) begin
                    state_nxt = DONE;
                    frame_nxt = frame_cnt + FRAME_W'(1);
                end else begin
                    state_nxt = RUN;
                    k_nxt     = k + IDX_W'(1);
                end
            end
            DONE: begin
                if (!abort && start) begin
                    state_nxt = RUN;
                    k_nxt     = ENC1;
                end else begin
                    state_nxt = IDLE;
                end
            end
`ifdef SEQ_TIMEOUT_EN
            ERR: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                    k_nxt     = ENC1;
                    err_nxt   = 1'b0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        clr_nxt  = '1;
        cap_nxt  = '0;
        idx_nxt  = IDX_NONE;
        busy_nxt = (state_nxt == RUN) || (state_nxt == CAPT);
        done_nxt = (state_nxt == DONE);
        if (busy_nxt) begin
            clr_nxt[k_nxt] = 1'b0;
            idx_nxt        = k_nxt;
        end
        if (state_nxt == CAPT) begin
            cap_nxt[k_nxt] = 1'b1;
        end
        if (state_nxt == ERR) begin
            idx_nxt = k_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= ENC1;
            stage_clr  <= '1;
            capture_en <= '0;
            stage_idx  <= IDX_NONE;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            stage_clr  <= clr_nxt;
            capture_en <= cap_nxt;
            stage_idx  <= idx_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            frame_cnt  <= frame_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
